// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: expands an AES-128 cipher key into round keys 0..NR by running one
//   shared combinational round-key step for NR cycles, and serves the keys from a bank.
// Latency: done pulses NR clocks after start is sampled; rd_data is registered (1 cycle).
// Backpressure: none; start is ignored while busy (no queuing), reads return 0 unless keys_valid.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   start        request expansion of key_in (sampled only in IDLE)
//   abort        (only with KEYSCHED_ABORT_EN) drop the running expansion, no done pulse
//   key_in       cipher key, [127:120] = byte 0, byte i -> row i%4, column i/4
//   busy         expansion in progress
//   done         one-cycle pulse once all NR+1 round keys are written
//   keys_valid   bank holds a complete key set (from done until next accepted start / rst)
//   rd_addr      round-key index 0..NR
//   rd_data      round key at rd_addr, registered; 0 when invalid or out of range
//
// Optional feature macro: KEYSCHED_ABORT_EN (adds the abort input).

module key_schedule_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef KEYSCHED_ABORT_EN
  input  logic         abort,
`endif
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_data
);

  localparam logic [3:0] NR_L = 4'(NR);

  // byte matrix as the round step sees it: [row][col]
  typedef logic [0:3][0:3][7:0] kmat_t;

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [7:0]   rcon;
  logic [127:0] cur;
  logic [127:0] gen_out;
  logic [127:0] bank [0:NR];
  logic         accept, step, finish;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers and S-box (multiplicative inverse followed by the affine map)
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    // x^254 = x^-1 (and maps 0 to 0): product of x^2, x^4, ..., x^128
    sq  = gmul(x, x);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // ---------------------------------------------------------------------------
  // Byte order conversion between the 128-bit bus and the [row][col] matrix
  // ---------------------------------------------------------------------------
  function automatic kmat_t unpack_key(input logic [127:0] k);
    kmat_t m;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = k[127 - 8*(4*c + r) -: 8];
    return m;
  endfunction

  function automatic logic [127:0] pack_key(input kmat_t m);
    logic [127:0] k;
    k = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        k[127 - 8*(4*c + r) -: 8] = m[r][c];
    return k;
  endfunction

  // One round of AES-128 key expansion (roundKeyGen): column 0 takes
  // SubWord(RotWord(col 3)) ^ rcon, each later column chains off the new previous one.
  function automatic kmat_t round_key_gen(input kmat_t m, input logic [7:0] rc);
    kmat_t          o;
    logic [0:3][7:0] t;
    for (int r = 0; r < 4; r++)
      t[r] = sbox(m[(r + 1) % 4][3]);
    t[0] = t[0] ^ rc;
    for (int r = 0; r < 4; r++)
      o[r][0] = m[r][0] ^ t[r];
    for (int c = 1; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[r][c] = m[r][c] ^ o[r][c-1];
    return o;
  endfunction

  always_comb begin
    gen_out = pack_key(round_key_gen(unpack_key(cur), rcon));
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
`ifdef KEYSCHED_ABORT_EN
        // abort beats a coinciding final round: the run is dropped without done
        if (abort) begin
          state_nxt = IDLE;
        end else
`endif
        begin
          step = 1'b1;
          if (cnt == NR_L) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      rd_data    <= '0;
      rcon       <= 8'h01;
      cnt        <= '0;
      cur        <= '0;
    end else begin
      busy <= (state_nxt == EXPAND);
      done <= finish;
      if (accept) begin
        cur        <= key_in;
        cnt        <= 4'd1;
        rcon       <= 8'h01;
        keys_valid <= 1'b0;
      end else if (step) begin
        cur  <= gen_out;
        cnt  <= cnt + 4'd1;
        rcon <= xtime(rcon);
      end
      if (finish) keys_valid <= 1'b1;
      // keys_valid is low for the whole run, so reads during expansion return 0
      rd_data <= (keys_valid && (rd_addr <= NR_L)) ? bank[rd_addr] : '0;
    end
  end

  // Bank has no reset; its contents only matter once keys_valid is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept)    bank[0]   <= key_in;
      else if (step) bank[cnt] <= gen_out;
    end
  end

endmodule
